// File: rtl/canon_voice_mixer.sv
// Two-voice envelope mixer: per-voice attack/release envelope, 2-stage signed mix,
// and an 8-bit PWM audio output whose duty is latched once per 256-clock period.
`timescale 1ns/1ps
module canon_voice_mixer #(
  parameter logic [15:0] ENV_DIV = 16'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample1,
  input  logic [7:0] sample2,
  input  logic       gate1,
  input  logic       gate2,
  input  logic [7:0] attack_rate,
  input  logic [7:0] release_rate,
  output logic [7:0] env1,
  output logic [7:0] env2,
  output logic [7:0] mix_level,
  output logic       period_start,
  output logic       pwm_out
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] level,
                                                 input logic [DATA_W-1:0] rate);
    logic [DATA_W:0] sum;
    sum = {1'b0, level} + {1'b0, rate};
    return (sum >= 9'd255) ? 8'hFF : sum[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] level,
                                                 input logic [DATA_W-1:0] rate);
    return (level <= rate) ? 8'h00 : level - rate;
  endfunction

  function automatic logic signed [DATA_W-1:0] scale_voice(input logic [DATA_W-1:0] sample,
                                                            input logic [DATA_W-1:0] env);
    logic signed [DATA_W:0]     s;
    logic signed [2*DATA_W+1:0] prod;
    s    = $signed({1'b0, sample}) - 9'sd128;
    prod = s * $signed({1'b0, env});
    // Result of >>> 8 always fits in 8 signed bits, so a slice is exact.
    return prod[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] mix_voices(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] biased;
    sum    = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    biased = (sum >>> 1) + 9'sd128;
    return biased[DATA_W-1:0];
  endfunction

  logic [15:0] tick_cnt;
  logic        tick;
  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= ENV_DIV;
    else if (tick) tick_cnt <= ENV_DIV;
    else           tick_cnt <= tick_cnt - 16'd1;
  end

  logic [1:0]        gate;
  env_state_t        state_q [2];
  env_state_t        state_d [2];
  logic [DATA_W-1:0] env_q   [2];
  logic [DATA_W-1:0] env_d   [2];
  assign gate = {gate2, gate1};

  always_ff @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        state_q[i] <= IDLE;
        env_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        env_q[i]   <= env_d[i];
      end
    end
  end

  // Gate edges take priority over ticks: a transition clock never moves the level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (gate[i]) state_d[i] = ATTACK;
        ATTACK:  if (!gate[i]) state_d[i] = RELEASE;
                 else if (tick && sat_add(env_q[i], attack_rate) == 8'hFF) state_d[i] = SUSTAIN;
        SUSTAIN: if (!gate[i]) state_d[i] = RELEASE;
        RELEASE: if (gate[i]) state_d[i] = ATTACK;
                 else if (tick && sat_sub(env_q[i], release_rate) == 8'h00) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      env_d[i] = env_q[i];
      case (state_q[i])
        IDLE:    env_d[i] = '0;
        ATTACK:  if (gate[i] && tick) env_d[i] = sat_add(env_q[i], attack_rate);
        RELEASE: if (!gate[i] && tick) env_d[i] = sat_sub(env_q[i], release_rate);
        default: env_d[i] = env_q[i];
      endcase
    end
  end

  assign env1 = env_q[0];
  assign env2 = env_q[1];

  // Stage 1: per-voice signed scaling
  logic signed [DATA_W-1:0] prod1_p1;
  logic signed [DATA_W-1:0] prod2_p1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod1_p1 <= '0;
      prod2_p1 <= '0;
    end else begin
      prod1_p1 <= scale_voice(sample1, env_q[0]);
      prod2_p1 <= scale_voice(sample2, env_q[1]);
    end
  end

  // Stage 2: sum, halve and re-bias to unsigned
  logic [DATA_W-1:0] mix_p2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mix_p2 <= 8'd128;
    else        mix_p2 <= mix_voices(prod1_p1, prod2_p1);
  end
  assign mix_level = mix_p2;

  logic [DATA_W-1:0] pwm_cnt;
  logic [DATA_W-1:0] duty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      duty         <= 8'd128;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 8'd1;
      period_start <= (pwm_cnt == 8'hFF);
      pwm_out      <= (pwm_cnt < duty);
      if (pwm_cnt == 8'hFF) duty <= mix_p2;
    end
  end

endmodule

// File: tb/tb_canon_voice_mixer.sv
// Randomised bench for canon_voice_mixer: an edge-counting behavioural model checked
// every clock, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_canon_voice_mixer;

  localparam logic [15:0] ENV_DIV = 16'd3;
  localparam int TICK_P = 4;
  localparam int M_IDLE = 0, M_ATT = 1, M_SUS = 2, M_REL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample1 = 8'd200, sample2 = 8'd200;
  logic       gate1 = 1'b0, gate2 = 1'b0;
  logic [7:0] attack_rate = 8'd0, release_rate = 8'd0;
  logic [7:0] env1, env2, mix_level;
  logic       period_start, pwm_out;

  canon_voice_mixer #(.ENV_DIV(ENV_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .sample1(sample1), .sample2(sample2),
    .gate1(gate1), .gate2(gate2), .attack_rate(attack_rate), .release_rate(release_rate),
    .env1(env1), .env2(env2), .mix_level(mix_level),
    .period_start(period_start), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  // Model state: edge count since reset release drives tick and PWM phase.
  int m_env [2] = '{0, 0};
  int m_mode[2] = '{M_IDLE, M_IDLE};
  int m_p   [2] = '{0, 0};
  int m_mix = 128, m_duty = 128, m_pwm = 0, m_ps = 0, m_e = 0;

  initial begin
    int cnt, nmix, nduty, s, g, tk;
    int np[2];
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_env = '{0, 0}; m_mode = '{M_IDLE, M_IDLE}; m_p = '{0, 0};
        m_mix = 128; m_duty = 128; m_pwm = 0; m_ps = 0; m_e = 0;
      end else begin
        m_e++;
        tk  = ((m_e % TICK_P) == 0) ? 1 : 0;
        cnt = (m_e - 1) % 256;
        for (int v = 0; v < 2; v++) begin
          s = (v == 0) ? int'(sample1) - 128 : int'(sample2) - 128;
          np[v] = floor_div(s * m_env[v], 256);
        end
        nmix  = floor_div(m_p[0] + m_p[1], 2) + 128;
        nduty = (cnt == 255) ? m_mix : m_duty;
        m_pwm = (cnt < m_duty) ? 1 : 0;
        m_ps  = (cnt == 255) ? 1 : 0;
        for (int v = 0; v < 2; v++) begin
          g = (v == 0) ? int'(gate1) : int'(gate2);
          case (m_mode[v])
            M_IDLE: begin m_env[v] = 0; if (g != 0) m_mode[v] = M_ATT; end
            M_ATT:  if (g == 0) m_mode[v] = M_REL;
                    else if (tk != 0) begin
                      if (m_env[v] + int'(attack_rate) >= 255) begin
                        m_env[v] = 255; m_mode[v] = M_SUS;
                      end else m_env[v] = m_env[v] + int'(attack_rate);
                    end
            M_SUS:  if (g == 0) m_mode[v] = M_REL;
            default: if (g != 0) m_mode[v] = M_ATT;
                    else if (tk != 0) begin
                      if (m_env[v] <= int'(release_rate)) begin
                        m_env[v] = 0; m_mode[v] = M_IDLE;
                      end else m_env[v] = m_env[v] - int'(release_rate);
                    end
          endcase
        end
        m_p = np; m_mix = nmix; m_duty = nduty;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (chk_en) begin
        check("model_env1", int'(env1), m_env[0]);
        check("model_env2", int'(env2), m_env[1]);
        check("model_mix", int'(mix_level), m_mix);
        check("model_period_start", int'(period_start), m_ps);
        check("model_pwm_out", int'(pwm_out), m_pwm);
      end
    end
  end

  task automatic wait_env1_change(output int val, output int dt);
    int prev;
    prev = int'(env1);
    dt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      dt++;
      if (int'(env1) != prev) break;
    end
    val = int'(env1);
  endtask

  task automatic wait_envs(input int t1, input int t2, input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (int'(env1) == t1 && (t2 < 0 || int'(env2) == t2)) break;
    end
    check(name, int'(env1), t1);
  endtask

  task automatic wait_ps();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (period_start) break;
    end
    check("period_start_seen", int'(period_start), 1);
  endtask

  // Positioned on a period_start sample: count pwm_out over the next 256 edges.
  task automatic measure(input int change_at, input logic [7:0] s_new,
                         output int highs, output int len);
    highs = 0; len = 0;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      highs += int'(pwm_out);
      if (period_start && len == 0) len = i;
      if (i == change_at) begin
        @(negedge clk); sample1 = s_new; sample2 = s_new;
      end
    end
  endtask

  initial begin
    int v, dt, h, len;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_env1", int'(env1), 0);
    check("rst_mix", int'(mix_level), 128);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    @(negedge clk) rst_n = 1'b1;

    // Silence: duty 128 from the first latched period on.
    wait_ps();
    measure(0, 8'd0, h, len);
    check("silence_highs", h, 128);
    check("silence_period_len", len, 256);
    check("silence_env1", int'(env1), 0);
    check("silence_mix", int'(mix_level), 128);

    @(negedge clk); attack_rate = 8'd100; release_rate = 8'd100; gate1 = 1'b1;
    wait_env1_change(v, dt); check("attack_1", v, 100);
    wait_env1_change(v, dt); check("attack_2", v, 200); check("attack_spacing", dt, TICK_P);
    wait_env1_change(v, dt); check("attack_3", v, 255); check("attack_spacing2", dt, TICK_P);
    repeat (12) @(posedge clk);
    #1 check("sustain_hold", int'(env1), 255);

    @(negedge clk) gate1 = 1'b0;
    wait_env1_change(v, dt); check("release_1", v, 155);
    wait_env1_change(v, dt); check("release_2", v, 55); check("release_spacing", dt, TICK_P);
    @(negedge clk) gate1 = 1'b1;
    wait_env1_change(v, dt); check("retrigger", v, 155);
    @(negedge clk) gate1 = 1'b0;
    wait_env1_change(v, dt); check("release_3", v, 55);
    wait_env1_change(v, dt); check("release_zero", v, 0);
    repeat (12) @(posedge clk);
    #1 check("idle_hold", int'(env1), 0);

    @(negedge clk); gate1 = 1'b1; gate2 = 1'b1;
    wait_envs(255, 255, "both_full");
    @(negedge clk); sample1 = 8'd255; sample2 = 8'd255;
    repeat (2) @(posedge clk);
    #1 check("mix_max", int'(mix_level), 254);
    @(negedge clk); sample1 = 8'd0; sample2 = 8'd0;
    repeat (2) @(posedge clk);
    #1 check("mix_min", int'(mix_level), 0);
    @(negedge clk); sample1 = 8'd255; sample2 = 8'd0;
    repeat (2) @(posedge clk);
    #1 check("mix_split", int'(mix_level), 127);

    // Duty latch: mid-period change must not affect the current period.
    @(negedge clk); sample1 = 8'd255; sample2 = 8'd255;
    repeat (3) @(posedge clk);
    wait_ps();
    measure(100, 8'd0, h, len);
    check("duty_254_highs", h, 254);
    check("duty_period_len", len, 256);
    measure(0, 8'd0, h, len);
    check("duty_0_highs", h, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sample1 = 8'($urandom_range(0, 255));
      sample2 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) gate1 = ~gate1;
      if ($urandom_range(0, 39) == 0) gate2 = ~gate2;
      if ($urandom_range(0, 199) == 0) attack_rate = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) release_rate = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) attack_rate = 8'd0;
    end

    // Async reset between edges, mid-attack.
    @(negedge clk); gate1 = 1'b0; gate2 = 1'b0; release_rate = 8'd255;
    sample1 = 8'd255; sample2 = 8'd128;
    wait_envs(0, 0, "pre_reset_idle");
    @(negedge clk); attack_rate = 8'd50; gate1 = 1'b1;
    wait_envs(150, -1, "pre_reset_150");
    #2 rst_n = 1'b0;
    #1;
    check("async_env1", int'(env1), 0);
    check("async_env2", int'(env2), 0);
    check("async_pwm", int'(pwm_out), 0);
    check("async_mix", int'(mix_level), 128);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
